// File: rtl/mpu_matrix_loader.sv
// Producer side of the MPU packed-matrix interface: takes a size, then size*size
// row-major elements, and presents the zero-filled packed matrix with valid/ready.
module mpu_matrix_loader #(
  parameter int ELEM_W  = 8,
  parameter int DIM_MAX = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_valid,
  input  logic [7:0]                        cfg_size,
  output logic                              cfg_ready,
  input  logic                              abort,
  input  logic                              in_valid,
  input  logic [ELEM_W-1:0]                 in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] out_matrix,
  output logic [7:0]                        out_size,
  input  logic                              out_ready,
  output logic                              size_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       started;
  logic [2:0] row;
  logic [2:0] col;
  logic [7:0] elem_idx;
  logic       cfg_fire;
  logic       size_ok;
  logic       elem_fire;
  logic       last_col;
  logic       last_row;
  logic       last_elem;

  // started holds cfg_ready low for the first cycle after reset
  assign cfg_ready = started && (state == IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == HOLD);

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign size_ok   = (cfg_size != 8'd0) && (cfg_size <= 8'(DIM_MAX));
  assign elem_fire = in_valid && in_ready && !abort;
  assign last_col  = ({5'b0, col} == (out_size - 8'd1));
  assign last_row  = ({5'b0, row} == (out_size - 8'd1));
  assign last_elem = last_col && last_row;
  // column-major packing: element (r,c) lives at slot r + DIM_MAX*c
  assign elem_idx  = 8'(row) + 8'(DIM_MAX) * 8'(col);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cfg_fire && size_ok) state_nxt = LOAD;
      LOAD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (elem_fire && last_elem) begin
          state_nxt = HOLD;
        end
      end
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started    <= 1'b0;
      out_matrix <= '0;
      out_size   <= '0;
      size_err   <= 1'b0;
      row        <= '0;
      col        <= '0;
    end else begin
      started  <= 1'b1;
      size_err <= cfg_fire && !size_ok;
      if (cfg_fire && size_ok) begin
        out_size   <= cfg_size;
        out_matrix <= '0;
        row        <= '0;
        col        <= '0;
      end else if ((state == LOAD) && abort) begin
        out_matrix <= '0;
        row        <= '0;
        col        <= '0;
      end else if (elem_fire) begin
        out_matrix[ELEM_W*elem_idx +: ELEM_W] <= in_data;
        if (last_col) begin
          col <= '0;
          // wrap row after the final element so it never reaches DIM_MAX
          row <= last_row ? 3'd0 : row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

endmodule
